// File: rtl/oled_str_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oled_pkg
//  Description : Shared types and constants for the OLED sequencer blocks:
//                string-writer state encoding, OLED field widths and the
//                default byte-buffer geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package oled_pkg;

    localparam int OLED_POS_W  = 8;
    localparam int OLED_DATA_W = 8;

    localparam int OLED_DEPTH  = 16;
    localparam int OLED_AW     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/oled_str_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : oled_str_writer_if
//  Description : Host-side buffer/command signals and the oled_disp_v2
//                handshake of the string writer, bundled into one interface.
//                slave  = string writer view, master = environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface oled_str_writer_if
    import oled_pkg::*;
#(
    parameter int AW = OLED_AW
) ();

    // host side
    logic                    wr_en;
    logic [OLED_DATA_W-1:0]  wr_data;
    logic                    buf_full;
    logic [AW:0]             buf_cnt;
    logic                    go;
    logic [OLED_POS_W-1:0]   go_pos;
    logic                    busy;
    logic                    done;

    // oled_disp_v2 side
    logic                    disp_rdy;
    logic                    disp_start;
    logic [OLED_POS_W-1:0]   disp_pos;
    logic [OLED_DATA_W-1:0]  disp_data;
    logic                    disp_seqential;
    logic                    disp_done;

    modport slave (
        input  wr_en, wr_data, go, go_pos, disp_rdy, disp_done,
        output buf_full, buf_cnt, busy, done,
               disp_start, disp_pos, disp_data, disp_seqential
    );

    modport master (
        output wr_en, wr_data, go, go_pos, disp_rdy, disp_done,
        input  buf_full, buf_cnt, busy, done,
               disp_start, disp_pos, disp_data, disp_seqential
    );

endinterface
`default_nettype wire

// File: rtl/oled_str_writer_byte_buf.sv
`default_nettype none
// ============================================================================
//  Module      : oled_byte_buf
//  Description : DEPTH x 8 append-only byte buffer. Writes land at index cnt
//                while not full; reads are combinational by index; clr empties
//                the buffer in one cycle. cnt and full are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_byte_buf
    import oled_pkg::*;
#(
    parameter int DEPTH = OLED_DEPTH,
    parameter int AW    = OLED_AW
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   clr,
    input  wire logic                   wr_en,
    input  wire logic [OLED_DATA_W-1:0] wr_data,
    input  wire logic [AW-1:0]          rd_idx,
    output logic      [OLED_DATA_W-1:0] rd_data,
    output logic      [AW:0]            cnt,
    output logic                        full
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [OLED_DATA_W-1:0] r_mem [DEPTH];
    logic                   w_we;
    logic [AW:0]            w_cnt_inc;

    // a full buffer silently drops further appends
    assign w_we      = wr_en && !full;
    assign w_cnt_inc = cnt + {{AW{1'b0}}, 1'b1};
    assign rd_data   = r_mem[rd_idx];

    // storage array; contents are only meaningful below cnt, so no reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[cnt[AW-1:0]] <= wr_data;
        end
    end

    // fill level and registered full flag
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            full <= 1'b0;
        end else if (w_we) begin
            cnt  <= w_cnt_inc;
            full <= (w_cnt_inc == c_depth);
        end
    end

endmodule
`default_nettype wire

// File: rtl/oled_str_writer.sv
`default_nettype none
// ============================================================================
//  Module      : oled_str_writer
//  Description : Streams a buffered byte string to one oled_disp_v2. The first
//                byte is a positioned write, every later byte a sequential
//                write; the rdy/start/done handshake is run per byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_str_writer
    import oled_pkg::*;
#(
    parameter int DEPTH = OLED_DEPTH,
    parameter int AW    = OLED_AW
) (
    input  wire logic         clk,
    input  wire logic         rst,
    oled_str_writer_if.slave  bus
);

    state_t                 r_state;
    logic [AW-1:0]          r_idx;
    logic [OLED_POS_W-1:0]  r_pos;

    logic                   w_wr_en;
    logic                   w_clr;
    logic [OLED_DATA_W-1:0] w_rd_data;
    logic [AW:0]            w_idx_inc;

    // appends only while idle; a go in the same cycle wins over the write
    assign w_wr_en   = bus.wr_en && (r_state == IDLE) && !bus.go;
    // the buffer empties on the same edge that raises done
    assign w_clr     = (r_state == FIN);
    // extra bit so a full DEPTH-byte string compares against cnt without wrap
    assign w_idx_inc = {1'b0, r_idx} + {{AW{1'b0}}, 1'b1};

    oled_byte_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .wr_en   (w_wr_en),
        .wr_data (bus.wr_data),
        .rd_idx  (r_idx),
        .rd_data (w_rd_data),
        .cnt     (bus.buf_cnt),
        .full    (bus.buf_full)
    );

    // transfer sequencer with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= IDLE;
            r_idx              <= '0;
            r_pos              <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.disp_start     <= 1'b0;
            bus.disp_pos       <= '0;
            bus.disp_data      <= '0;
            bus.disp_seqential <= 1'b0;
        end else begin
            bus.disp_start <= 1'b0;
            bus.done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.go) begin
                        if (bus.buf_cnt != '0) begin
                            r_pos    <= bus.go_pos;
                            r_idx    <= '0;
                            bus.busy <= 1'b1;
                            r_state  <= ISSUE;
                        end else begin
                            r_state  <= FIN;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.disp_rdy) begin
                        bus.disp_start     <= 1'b1;
                        bus.disp_pos       <= r_pos;
                        bus.disp_data      <= w_rd_data;
                        bus.disp_seqential <= (r_idx != '0);
                        r_state            <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.disp_done) begin
                        if (w_idx_inc == bus.buf_cnt) begin
                            r_state <= FIN;
                        end else begin
                            r_idx   <= w_idx_inc[AW-1:0];
                            r_state <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oled_str_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oled_str_writer
//  Description : Self-checking bench for oled_str_writer with an oled_disp_v2
//                stand-in and a queue-based model of the string buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_str_writer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    oled_str_writer_if #(.AW(AW)) bus ();

    oled_str_writer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // oled_disp_v2 stand-in state
    int dcount      = 0;
    bit hold_rdy    = 1'b0;
    bit rnd_stall   = 1'b0;
    bit inject_done = 1'b0;

    // observed traffic
    logic [7:0] ev_pos[$];
    logic [7:0] ev_data[$];
    logic       ev_seq[$];
    int done_cnt, done_cyc, first_start_cyc, last_dd_cyc, go_cyc;
    int width_bad, busy_bad;
    bit prev_start = 1'b0;
    bit in_xfer    = 1'b0;

    // reference contents of the string buffer
    logic [7:0] mbuf[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // one clock: observe DUT outputs, then update the downstream stand-in
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.disp_start) begin
            ev_pos.push_back(bus.disp_pos);
            ev_data.push_back(bus.disp_data);
            ev_seq.push_back(bus.disp_seqential);
            if (ev_pos.size() == 1) first_start_cyc = cyc;
        end
        if (bus.disp_start && prev_start) width_bad++;
        prev_start = bus.disp_start;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (in_xfer) begin
            if (bus.done) begin
                if (bus.busy) busy_bad++;
                in_xfer = 1'b0;
            end else if (!bus.busy) begin
                busy_bad++;
            end
        end
        if (bus.disp_start) dcount = 3;
        else if (dcount > 0) dcount--;
        if (rnd_stall) hold_rdy = ($urandom_range(0, 2) == 0);
        bus.disp_done = (dcount == 1) || inject_done;
        if (dcount == 1) last_dd_cyc = cyc;
        bus.disp_rdy  = (dcount == 0) && !hold_rdy;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
        if (mbuf.size() < DEPTH) mbuf.push_back(b);
    endtask

    task automatic chk_level(input string tag);
        chk({tag, "_cnt"}, 32'(bus.buf_cnt), mbuf.size());
        chk({tag, "_full"}, 32'(bus.buf_full), 32'(mbuf.size() == DEPTH));
    endtask

    // run one go-to-done transfer and compare it against the buffered string
    task automatic run_xfer(input logic [7:0] pos, input int hold, input bit spurious, input bit rnd_wr);
        logic [7:0] exp_q[$];
        int n;
        exp_q = mbuf;
        n     = exp_q.size();
        ev_pos.delete(); ev_data.delete(); ev_seq.delete();
        done_cnt = 0; width_bad = 0; busy_bad = 0;
        bus.go      = 1'b1;
        bus.go_pos  = pos;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'($urandom);
        hold_rdy    = (hold > 0);
        go_cyc      = cyc;
        tick();
        bus.go    = 1'b0;
        bus.wr_en = 1'b0;
        in_xfer   = (n > 0);
        for (int t = 1; t < 800 && done_cnt == 0; t++) begin
            if (rnd_wr) begin
                bus.wr_en   = 1'($urandom_range(0, 1));
                bus.wr_data = 8'($urandom);
            end
            if (hold > 0 && t == hold) begin
                chk("rdy_hold_nostart", ev_pos.size(), 0);
                hold_rdy = 1'b0;
            end
            inject_done = spurious && (t == 3);
            tick();
        end
        inject_done = 1'b0;
        bus.wr_en   = 1'b0;
        repeat (3) tick();
        in_xfer = 1'b0;
        chk("done_pulses", done_cnt, 1);
        chk("start_count", ev_pos.size(), n);
        for (int i = 0; i < n && i < ev_pos.size(); i++) begin
            chk($sformatf("data[%0d]", i), 32'(ev_data[i]), 32'(exp_q[i]));
            chk($sformatf("seq[%0d]", i), 32'(ev_seq[i]), 32'(i != 0));
            if (i == 0) chk("pos[0]", 32'(ev_pos[i]), 32'(pos));
        end
        chk("start_width", width_bad, 0);
        chk("busy_window", busy_bad, 0);
        chk("busy_after", 32'(bus.busy), 0);
        chk("cnt_after", 32'(bus.buf_cnt), 0);
        if (!rnd_stall) begin
            if (n == 0) begin
                chk("empty_done_lat", done_cyc - go_cyc, 2);
            end else begin
                chk("first_start_lat", first_start_cyc - go_cyc, (hold > 0) ? hold + 2 : 2);
                chk("done_lat", done_cyc - last_dd_cyc, 2);
            end
        end
        mbuf.delete();
    endtask

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.go      = 1'b0;
        bus.go_pos  = '0;
        bus.disp_rdy  = 1'b1;
        bus.disp_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_cnt", 32'(bus.buf_cnt), 0);
        chk("rst_full", 32'(bus.buf_full), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_start", 32'(bus.disp_start), 0);
        chk("rst_pos", 32'(bus.disp_pos), 0);
        chk("rst_data", 32'(bus.disp_data), 0);
        chk("rst_seq", 32'(bus.disp_seqential), 0);

        // three-byte string
        push_byte(8'hAB); push_byte(8'hCD); push_byte(8'hEF);
        chk_level("t1");
        run_xfer(8'h35, 0, 1'b0, 1'b0);

        // single byte
        push_byte(8'h12);
        chk_level("t2");
        run_xfer(8'h00, 0, 1'b0, 1'b0);

        // empty buffer
        run_xfer(8'h77, 0, 1'b0, 1'b0);

        // downstream not ready for 10 cycles, spurious done while issuing
        push_byte(8'h5C); push_byte(8'hC5);
        run_xfer(8'h40, 10, 1'b1, 1'b0);

        // overfill: the last two bytes are dropped
        for (int i = 0; i < DEPTH + 2; i++) push_byte(8'(i));
        chk_level("t5");
        run_xfer(8'h01, 0, 1'b0, 1'b1);

        // reset in the middle of the second byte of three
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        ev_pos.delete(); ev_data.delete(); ev_seq.delete();
        done_cnt   = 0;
        bus.go     = 1'b1;
        bus.go_pos = 8'h22;
        tick();
        bus.go = 1'b0;
        for (int t = 0; t < 100 && ev_pos.size() < 2; t++) tick();
        chk("t6_reach_byte2", ev_pos.size(), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mbuf.delete();
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_start", 32'(bus.disp_start), 0);
        chk("t6_pos", 32'(bus.disp_pos), 0);
        chk("t6_data", 32'(bus.disp_data), 0);
        chk("t6_seq", 32'(bus.disp_seqential), 0);
        chk("t6_cnt", 32'(bus.buf_cnt), 0);
        repeat (8) tick();
        chk("t6_no_done", done_cnt, 0);
        chk("t6_no_restart", ev_pos.size(), 2);
        push_byte(8'h9E);
        run_xfer(8'h10, 0, 1'b0, 1'b0);

        // randomized strings with random downstream stalls
        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(0, DEPTH + 2);
            for (int i = 0; i < n; i++) push_byte(8'($urandom));
            chk_level("rnd");
            rnd_stall = it[0];
            run_xfer(8'($urandom), 0, 1'b0, 1'b1);
            rnd_stall = 1'b0;
            hold_rdy  = 1'b0;
            repeat (4) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
